usb_cmd_rx: RTL and testbench

Host-to-device command receiver for the USB oscilloscope. It reads bytes from the USB FIFO chip's synchronous 245-mode receive side (rxf/oe/rd), the opposite direction of the sample-streaming FIFO writer. It parses fixed 5-byte command packets and holds the scope configuration registers (volts/div, time/div, trigger level, channel, run/stop), so the host can drive the same settings the rotary encoders and switch drive. It shares the FIFO chip's data bus with the transmit path and arbitrates with it through tx_active/rx_active.

---
 rtl/usb_cmd_rx_if.sv | 28 ++
 rtl/usb_cmd_rx.sv | 186 ++++++++++++++++++
 tb/tb_usb_cmd_rx.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_cmd_rx_if.sv
// Receive-side signals of the FIFO chip bus in synchronous 245 mode,
// plus the tx/rx ownership handshake shared with the transmit path.
interface usb_cmd_rx_if;
    logic       rxf;
    logic [7:0] data_in;
    logic       tx_active;
    logic       oe;
    logic       rd;
    logic       rx_active;

    modport master (
        output rxf,
        output data_in,
        output tx_active,
        input  oe,
        input  rd,
        input  rx_active
    );

    modport slave (
        input  rxf,
        input  data_in,
        input  tx_active,
        output oe,
        output rd,
        output rx_active
    );
endinterface

// File: rtl/usb_cmd_rx.sv
// Host command receiver: reads the FIFO chip's receive side in bounded bursts,
// parses 5-byte A5 packets and holds the scope configuration registers.
module usb_cmd_rx #(
    parameter int MAX_BURST      = 64,
    parameter int TIMEOUT_CYCLES = 60000
) (
    input  logic         i_clk_in,
    input  logic         i_reset,
    usb_cmd_rx_if.slave  bus,
    output logic [3:0]   o_volt_sel,
    output logic [3:0]   o_time_sel,
    output logic [11:0]  o_trig_level,
    output logic         o_ch_sel,
    output logic         o_run,
    output logic         o_cfg_update,
    output logic [7:0]   o_err_count
);
    localparam int            BW         = $clog2(MAX_BURST + 1);
    localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    SYNC_BYTE  = 8'hA5;

    typedef enum logic [1:0] {B_IDLE, B_TURN, B_READ, B_RELEASE} bus_state_t;
    typedef enum logic [2:0] {P_SYNC, P_OP, P_VHI, P_VLO, P_CSUM} prs_state_t;

    bus_state_t    r_bus_state, w_bus_next;
    logic [BW-1:0] r_burst_cnt;
    logic          w_oe, w_rd, w_rx_active, w_capture;
    logic [7:0]    r_rx_byte;
    logic          r_rx_valid;

    prs_state_t    r_prs_state, w_prs_next;
    logic [7:0]    r_opcode, r_val_hi, r_val_lo;
    logic [TW-1:0] r_idle_cnt;
    logic          w_timeout, w_pkt_ok, w_pkt_bad, w_val_ok;
    logic [15:0]   w_value;

    logic [3:0]    r_volt_sel, r_time_sel;
    logic [11:0]   r_trig_level;
    logic          r_ch_sel, r_run, r_cfg_update;
    logic [7:0]    r_err_count;

    assign w_capture = (r_bus_state == B_READ) && !bus.rxf;

    always_ff @(posedge i_clk_in) begin
        if (i_reset) begin
            r_bus_state <= B_IDLE;
            r_burst_cnt <= '0;
            r_rx_byte   <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            r_bus_state <= w_bus_next;
            r_rx_valid  <= w_capture;
            if (w_capture) begin
                r_rx_byte   <= bus.data_in;
                r_burst_cnt <= r_burst_cnt + BW'(1);
            end else if (r_bus_state == B_RELEASE) begin
                r_burst_cnt <= '0;
            end
        end
    end

    // Bus outputs are pure functions of state so reset forces them idle at the edge.
    always_comb begin
        w_bus_next  = r_bus_state;
        w_oe        = 1'b1;
        w_rd        = 1'b1;
        w_rx_active = 1'b0;
        case (r_bus_state)
            B_IDLE: begin
                if (!bus.rxf && !bus.tx_active) w_bus_next = B_TURN;
            end
            B_TURN: begin
                w_oe        = 1'b0;
                w_rx_active = 1'b1;
                w_bus_next  = B_READ;
            end
            B_READ: begin
                w_oe        = 1'b0;
                w_rd        = 1'b0;
                w_rx_active = 1'b1;
                if (bus.rxf || (r_burst_cnt == BURST_LAST)) w_bus_next = B_RELEASE;
            end
            B_RELEASE: begin
                w_rx_active = 1'b1;
                w_bus_next  = B_IDLE;
            end
            default: w_bus_next = B_IDLE;
        endcase
    end

    assign bus.oe        = w_oe;
    assign bus.rd        = w_rd;
    assign bus.rx_active = w_rx_active;

    assign w_value = {r_val_hi, r_val_lo};

    always_comb begin
        w_val_ok = 1'b0;
        case (r_opcode)
            8'h01:        w_val_ok = (w_value <= 16'd9);
            8'h02:        w_val_ok = (w_value <= 16'd11);
            8'h03:        w_val_ok = (r_val_hi[7:4] == 4'h0);
            8'h04, 8'h05: w_val_ok = (w_value <= 16'd1);
            default:      w_val_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_prs_next = r_prs_state;
        w_pkt_ok   = 1'b0;
        w_pkt_bad  = 1'b0;
        w_timeout  = (r_prs_state != P_SYNC) && !r_rx_valid && (r_idle_cnt == IDLE_LAST);
        if (w_timeout) begin
            w_prs_next = P_SYNC;
        end else if (r_rx_valid) begin
            case (r_prs_state)
                P_SYNC: if (r_rx_byte == SYNC_BYTE) w_prs_next = P_OP;
                P_OP:   w_prs_next = P_VHI;
                P_VHI:  w_prs_next = P_VLO;
                P_VLO:  w_prs_next = P_CSUM;
                P_CSUM: begin
                    w_prs_next = P_SYNC;
                    if ((r_rx_byte == (r_opcode ^ r_val_hi ^ r_val_lo)) && w_val_ok)
                        w_pkt_ok = 1'b1;
                    else
                        w_pkt_bad = 1'b1;
                end
                default: w_prs_next = P_SYNC;
            endcase
        end
    end

    always_ff @(posedge i_clk_in) begin
        if (i_reset) begin
            r_prs_state  <= P_SYNC;
            r_opcode     <= '0;
            r_val_hi     <= '0;
            r_val_lo     <= '0;
            r_idle_cnt   <= '0;
            r_volt_sel   <= 4'd4;
            r_time_sel   <= 4'd6;
            r_trig_level <= 12'h800;
            r_ch_sel     <= 1'b0;
            r_run        <= 1'b1;
            r_cfg_update <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_prs_state  <= w_prs_next;
            r_cfg_update <= w_pkt_ok;
            if ((r_prs_state == P_SYNC) || r_rx_valid || w_timeout)
                r_idle_cnt <= '0;
            else
                r_idle_cnt <= r_idle_cnt + TW'(1);
            if (r_rx_valid) begin
                case (r_prs_state)
                    P_OP:    r_opcode <= r_rx_byte;
                    P_VHI:   r_val_hi <= r_rx_byte;
                    P_VLO:   r_val_lo <= r_rx_byte;
                    default: ;
                endcase
            end
            if (w_pkt_ok) begin
                case (r_opcode)
                    8'h01:   r_volt_sel   <= r_val_lo[3:0];
                    8'h02:   r_time_sel   <= r_val_lo[3:0];
                    8'h03:   r_trig_level <= w_value[11:0];
                    8'h04:   r_ch_sel     <= r_val_lo[0];
                    8'h05:   r_run        <= r_val_lo[0];
                    default: ;
                endcase
            end
            if ((w_pkt_bad || w_timeout) && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;
        end
    end

    assign o_volt_sel   = r_volt_sel;
    assign o_time_sel   = r_time_sel;
    assign o_trig_level = r_trig_level;
    assign o_ch_sel     = r_ch_sel;
    assign o_run        = r_run;
    assign o_cfg_update = r_cfg_update;
    assign o_err_count  = r_err_count;
endmodule

// File: tb/tb_usb_cmd_rx.sv
// Bench for usb_cmd_rx: two instances (long and short burst) fed identical byte
// streams from FIFO queues, checked every cycle against a packet-level model.
module tb_usb_cmd_rx;
    localparam int TO   = 200;
    localparam int MB_A = 64;
    localparam int MB_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  = 1'b1;
    logic       tx   = 1'b0;
    logic       hold = 1'b0;
    logic       chk_en = 1'b0;
    logic       rxf_d [2] = '{1'b1, 1'b1};
    logic [7:0] data_d [2] = '{8'h00, 8'h00};
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         upd_t_a [$];
    int         grants_a = 0;
    int         grants_b = 0;
    logic       ra_prev_a = 1'b0;
    logic       ra_prev_b = 1'b0;

    usb_cmd_rx_if if_a ();
    usb_cmd_rx_if if_b ();
    assign if_a.rxf = rxf_d[0];
    assign if_a.data_in = data_d[0];
    assign if_a.tx_active = tx;
    assign if_b.rxf = rxf_d[1];
    assign if_b.data_in = data_d[1];
    assign if_b.tx_active = tx;

    logic [3:0]  volt_a, volt_b, time_a, time_b;
    logic [11:0] trig_a, trig_b;
    logic        ch_a, ch_b, run_a, run_b, upd_a, upd_b;
    logic [7:0]  err_a, err_b;

    usb_cmd_rx #(.MAX_BURST(MB_A), .TIMEOUT_CYCLES(TO)) dut_a (
        .i_clk_in(clk), .i_reset(rst), .bus(if_a),
        .o_volt_sel(volt_a), .o_time_sel(time_a), .o_trig_level(trig_a),
        .o_ch_sel(ch_a), .o_run(run_a), .o_cfg_update(upd_a), .o_err_count(err_a)
    );
    usb_cmd_rx #(.MAX_BURST(MB_B), .TIMEOUT_CYCLES(TO)) dut_b (
        .i_clk_in(clk), .i_reset(rst), .bus(if_b),
        .o_volt_sel(volt_b), .o_time_sel(time_b), .o_trig_level(trig_b),
        .o_ch_sel(ch_b), .o_run(run_b), .o_cfg_update(upd_b), .o_err_count(err_b)
    );

    logic [33:0] dvec [2];
    assign dvec[0] = {if_a.oe, if_a.rd, if_a.rx_active, volt_a, time_a, trig_a, ch_a, run_a, upd_a, err_a};
    assign dvec[1] = {if_b.oe, if_b.rd, if_b.rx_active, volt_b, time_b, trig_b, ch_b, run_b, upd_b, err_b};

    // Model: phase 0 idle, 1 turnaround, 2 reading, 3 release; packet kept as a byte list.
    int         m_phase [2];
    int         m_cnt [2];
    logic       m_pend [2];
    logic [7:0] m_byte [2];
    logic [7:0] m_pk [2][5];
    int         m_pkn [2];
    int         m_idle [2];
    logic [3:0] m_volt [2];
    logic [3:0] m_time [2];
    logic [11:0] m_trig [2];
    logic       m_ch [2];
    logic       m_run [2];
    logic       m_upd [2];
    int         m_err [2];

    task automatic bump_err(input int k);
        if (m_err[k] < 255) m_err[k]++;
    endtask

    task automatic apply_pkt(input int k);
        logic [7:0] op;
        int         val;
        logic       ok;
        op  = m_pk[k][1];
        val = int'(m_pk[k][2]) * 256 + int'(m_pk[k][3]);
        case (op)
            8'h01:        ok = (val <= 9);
            8'h02:        ok = (val <= 11);
            8'h03:        ok = (val < 4096);
            8'h04, 8'h05: ok = (val <= 1);
            default:      ok = 1'b0;
        endcase
        if (m_pk[k][4] != (op ^ m_pk[k][2] ^ m_pk[k][3])) ok = 1'b0;
        if (!ok) begin
            bump_err(k);
        end else begin
            m_upd[k] = 1'b1;
            case (op)
                8'h01:   m_volt[k] = 4'(val);
                8'h02:   m_time[k] = 4'(val);
                8'h03:   m_trig[k] = 12'(val);
                8'h04:   m_ch[k]   = 1'(val);
                default: m_run[k]  = 1'(val);
            endcase
        end
    endtask

    task automatic consume(input int k, input logic [7:0] b);
        if (m_pkn[k] == 0) begin
            if (b == 8'hA5) begin
                m_pk[k][0] = b;
                m_pkn[k] = 1;
            end
        end else begin
            m_pk[k][m_pkn[k]] = b;
            m_pkn[k]++;
            if (m_pkn[k] == 5) begin
                m_pkn[k] = 0;
                apply_pkt(k);
            end
        end
    endtask

    task automatic model_step(input int k);
        logic       nb_pend;
        logic [7:0] nb;
        int         mb;
        mb = (k == 0) ? MB_A : MB_B;
        nb_pend = 1'b0;
        nb = 8'h00;
        if (rst) begin
            m_phase[k] = 0; m_cnt[k] = 0; m_pend[k] = 1'b0; m_pkn[k] = 0; m_idle[k] = 0;
            m_volt[k] = 4'd4; m_time[k] = 4'd6; m_trig[k] = 12'h800;
            m_ch[k] = 1'b0; m_run[k] = 1'b1; m_upd[k] = 1'b0; m_err[k] = 0;
            return;
        end
        m_upd[k] = 1'b0;
        if (m_pend[k]) begin
            m_idle[k] = 0;
            consume(k, m_byte[k]);
        end else if (m_pkn[k] > 0) begin
            m_idle[k]++;
            if (m_idle[k] == TO) begin
                m_pkn[k] = 0;
                m_idle[k] = 0;
                bump_err(k);
            end
        end
        case (m_phase[k])
            0: if (!rxf_d[k] && !tx) m_phase[k] = 1;
            1: m_phase[k] = 2;
            2: begin
                if (rxf_d[k]) begin
                    m_phase[k] = 3;
                end else begin
                    nb_pend = 1'b1;
                    nb = data_d[k];
                    if (k == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                    m_cnt[k]++;
                    if (m_cnt[k] == mb) m_phase[k] = 3;
                end
            end
            default: begin
                m_phase[k] = 0;
                m_cnt[k] = 0;
            end
        endcase
        m_pend[k] = nb_pend;
        m_byte[k] = nb;
    endtask

    function automatic logic [33:0] mvec(input int k);
        logic oe, rd, ra;
        oe = !((m_phase[k] == 1) || (m_phase[k] == 2));
        rd = (m_phase[k] != 2);
        ra = (m_phase[k] != 0);
        return {oe, rd, ra, m_volt[k], m_time[k], m_trig[k], m_ch[k], m_run[k], m_upd[k], 8'(m_err[k])};
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) model_step(k);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_checks += 2;
            if (dvec[0] !== mvec(0)) begin
                n_errors++;
                $display("FAIL cycle_a cyc=%0d got=%h exp=%h", cyc, dvec[0], mvec(0));
            end
            if (dvec[1] !== mvec(1)) begin
                n_errors++;
                $display("FAIL cycle_b cyc=%0d got=%h exp=%h", cyc, dvec[1], mvec(1));
            end
            if (upd_a) upd_t_a.push_back(cyc);
            if (if_a.rx_active && !ra_prev_a) grants_a++;
            if (if_b.rx_active && !ra_prev_b) grants_b++;
        end
        ra_prev_a = if_a.rx_active;
        ra_prev_b = if_b.rx_active;
        rxf_d[0]  = !((q0.size() > 0) && !hold);
        data_d[0] = (q0.size() > 0) ? q0[0] : 8'h00;
        rxf_d[1]  = !((q1.size() > 0) && !hold);
        data_d[1] = (q1.size() > 0) ? q1[0] : 8'h00;
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push1(input logic [7:0] b);
        q0.push_back(b);
        q1.push_back(b);
    endtask

    task automatic pkt(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] cs_flip);
        push1(8'hA5); push1(op); push1(hi); push1(lo); push1(op ^ hi ^ lo ^ cs_flip);
    endtask

    task automatic drain();
        int t;
        t = 0;
        tx = 1'b0;
        hold = 1'b0;
        while (t < 3000 && !(q0.size() == 0 && q1.size() == 0 && m_phase[0] == 0 && m_phase[1] == 0
                             && !m_pend[0] && !m_pend[1])) begin
            step(1);
            t++;
        end
        n_checks++;
        if (t >= 3000) begin
            n_errors++;
            $display("FAIL drain_bound got=%0d cycles exp<3000", t);
        end
        step(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        q0.delete();
        q1.delete();
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        int         c0, n0, g0a, g0b, kind, nw;
        logic [7:0] op, hi, lo;

        step(3);
        chk_en = 1'b1;
        lit("rst_oe", 32'(if_a.oe), 1);
        lit("rst_rd", 32'(if_a.rd), 1);
        lit("rst_rx_active", 32'(if_a.rx_active), 0);
        lit("rst_volt", 32'(volt_a), 4);
        lit("rst_time", 32'(time_a), 6);
        lit("rst_trig", 32'(trig_a), 32'h800);
        lit("rst_ch_run", 32'({ch_a, run_a}), 1);
        lit("rst_upd_err", 32'({upd_a, err_a}), 0);
        rst = 1'b0;

        c0 = cyc;
        n0 = upd_t_a.size();
        push1(8'hA5); push1(8'h01); push1(8'h00); push1(8'h07); push1(8'h06);
        drain();
        lit("t1_volt", 32'(volt_a), 7);
        lit("t1_err", 32'(err_a), 0);
        lit("t1_oe_rd", 32'({if_a.oe, if_a.rd}), 3);
        lit("t1_upd_count", 32'(upd_t_a.size() - n0), 1);
        lit("t1_upd_cycle", 32'(upd_t_a[n0]), 32'(c0 + 8));
        lit("t1_model_volt", 32'(m_volt[0]), 7);

        n0 = upd_t_a.size();
        pkt(8'h03, 8'h08, 8'h00, 8'h00);
        pkt(8'h04, 8'h00, 8'h01, 8'h00);
        drain();
        lit("t2_trig", 32'(trig_a), 32'h800);
        lit("t2_ch", 32'(ch_a), 1);
        lit("t2_ch_b", 32'(ch_b), 1);
        lit("t2_upd_count", 32'(upd_t_a.size() - n0), 2);
        if (upd_t_a.size() - n0 == 2) lit("t2_upd_gap", 32'(upd_t_a[n0 + 1] - upd_t_a[n0]), 5);

        do_reset();
        n0 = upd_t_a.size();
        push1(8'hA5); push1(8'h02); push1(8'h00); push1(8'h05); push1(8'h00);
        push1(8'hA5); push1(8'h01); push1(8'h00); push1(8'h0C); push1(8'h0D);
        drain();
        lit("t3_time", 32'(time_a), 6);
        lit("t3_volt", 32'(volt_a), 4);
        lit("t3_err", 32'(err_a), 2);
        lit("t3_err_b", 32'(err_b), 2);
        lit("t3_upd_count", 32'(upd_t_a.size() - n0), 0);
        lit("t3_model_err", 32'(m_err[0]), 2);

        do_reset();
        push1(8'h00); push1(8'hFF); push1(8'h12);
        pkt(8'h05, 8'h00, 8'h00, 8'h00);
        drain();
        lit("t4_run", 32'(run_a), 0);
        lit("t4_err", 32'(err_a), 0);
        tx = 1'b1;
        pkt(8'h01, 8'h00, 8'h02, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step(1);
            lit("t4_tx_hold_off", 32'({if_a.oe, if_a.rd, if_b.oe, if_b.rd}), 32'hF);
        end
        drain();
        lit("t4_volt_after_tx", 32'(volt_a), 2);

        g0a = grants_a;
        g0b = grants_b;
        pkt(8'h01, 8'h00, 8'h03, 8'h00);
        pkt(8'h02, 8'h00, 8'h0B, 8'h00);
        drain();
        lit("t5_grants_a", 32'(grants_a - g0a), 1);
        lit("t5_grants_b", 32'(grants_b - g0b), 3);
        lit("t5_volt_b", 32'(volt_b), 3);
        lit("t5_time_b", 32'(time_b), 11);
        lit("t5_time_a", 32'(time_a), 11);

        do_reset();
        push1(8'hA5); push1(8'h01);
        drain();
        lit("t6_model_pending", 32'(m_pkn[0]), 2);
        step(TO + 5);
        lit("t6_err", 32'(err_a), 1);
        lit("t6_err_b", 32'(err_b), 1);
        lit("t6_model_sync", 32'(m_pkn[0]), 0);
        pkt(8'h01, 8'h00, 8'h01, 8'h00);
        drain();
        lit("t6_volt_after", 32'(volt_a), 1);

        pkt(8'h01, 8'h00, 8'h09, 8'h00);
        pkt(8'h01, 8'h00, 8'h09, 8'h00);
        step(5);
        lit("t7_mid_read", 32'({if_a.oe, if_a.rd, if_a.rx_active}), 1);
        rst = 1'b1;
        step(1);
        lit("t7_bus", 32'({if_a.oe, if_a.rd, if_a.rx_active}), 6);
        lit("t7_cfg", 32'({volt_a, time_a, trig_a, ch_a, run_a}), 32'({4'd4, 4'd6, 12'h800, 1'b0, 1'b1}));
        lit("t7_err", 32'(err_a), 0);
        q0.delete();
        q1.delete();
        step(1);
        rst = 1'b0;
        step(2);

        for (int p = 0; p < 220; p++) begin
            kind = int'($urandom_range(0, 11));
            op = 8'($urandom_range(1, 5));
            hi = 8'h00;
            case (op)
                8'h01:   lo = 8'($urandom_range(0, 9));
                8'h02:   lo = 8'($urandom_range(0, 11));
                8'h03:   begin hi = 8'($urandom_range(0, 15)); lo = 8'($urandom); end
                default: lo = 8'($urandom_range(0, 1));
            endcase
            if ($urandom_range(0, 5) == 0) hold = 1'b1;
            case (kind)
                5: begin
                    op = 8'($urandom_range(0, 7));
                    hi = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                    lo = 8'($urandom_range(0, 20));
                    pkt(op, hi, lo, 8'h00);
                end
                6: pkt(op, hi, lo, 8'($urandom_range(1, 255)));
                7: begin
                    nw = int'($urandom_range(1, 3));
                    for (int j = 0; j < nw; j++) push1(8'($urandom));
                end
                8: begin
                    push1(8'hA5); push1(op);
                    step(TO + 20);
                    push1(hi); push1(lo); push1(op ^ hi ^ lo);
                end
                9: begin
                    push1(8'hA5); push1(op); push1(hi);
                    step(int'($urandom_range(1, 30)));
                    push1(lo); push1(op ^ hi ^ lo);
                end
                default: pkt(op, hi, lo, 8'h00);
            endcase
            if (hold) begin
                step(int'($urandom_range(3, 40)));
                hold = 1'b0;
            end
            if ($urandom_range(0, 4) == 0) begin
                tx = 1'b1;
                step(int'($urandom_range(1, 15)));
                tx = 1'b0;
            end
            step(int'($urandom_range(0, 6)));
        end
        drain();
        step(TO + 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
